// File: rtl/axi_rd_burst_split.sv
// Splits an upstream AXI read burst into single-beat downstream reads,
// one outstanding at a time, replaying each beat upstream with burst-level ID/last.
module axi_rd_burst_split #(
  parameter int TAGW = 1
) (
  input  logic            aclk,
  input  logic            rst_l,
  input  logic            s_arvalid,
  output logic            s_arready,
  input  logic [31:0]     s_araddr,
  input  logic [TAGW-1:0] s_arid,
  input  logic [7:0]      s_arlen,
  input  logic [1:0]      s_arburst,
  input  logic [2:0]      s_arsize,
  output logic            s_rvalid,
  input  logic            s_rready,
  output logic [63:0]     s_rdata,
  output logic [1:0]      s_rresp,
  output logic [TAGW-1:0] s_rid,
  output logic            s_rlast,
  output logic            m_arvalid,
  input  logic            m_arready,
  output logic [31:0]     m_araddr,
  output logic [TAGW-1:0] m_arid,
  output logic [7:0]      m_arlen,
  output logic [1:0]      m_arburst,
  output logic [2:0]      m_arsize,
  input  logic            m_rvalid,
  output logic            m_rready,
  input  logic [63:0]     m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic [TAGW-1:0] m_rid,
  input  logic            m_rlast
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]      r_state;
  logic [31:0]     r_addr;
  logic [TAGW-1:0] r_id;
  logic [7:0]      r_len;
  logic [1:0]      r_burst;
  logic [2:0]      r_size;
  logic [7:0]      r_cnt;
  logic [63:0]     r_data;
  logic [1:0]      r_resp;

  logic [2:0]  w_esize;
  logic [31:0] w_step;
  logic [31:0] w_incr;
  logic [31:0] w_mask;
  logic        w_wrap;
  logic [31:0] w_next;
  logic        w_last;

  // Every beat is single-beat downstream, so its ID and last flag carry no information.
  logic w_unused;
  assign w_unused = &{1'b0, m_rid, m_rlast};

  assign w_esize = (s_arsize > 3'd3) ? 3'd3 : s_arsize;
  assign w_step  = 32'd1 << r_size;
  assign w_incr  = r_addr + w_step;
  assign w_wrap  = (r_burst == 2'b10) &&
                   ((r_len == 8'd1) || (r_len == 8'd3) || (r_len == 8'd7) || (r_len == 8'd15));
  // Span is a power of two, so wrapping keeps the high bits and lets the low bits roll over.
  assign w_mask  = ((32'(r_len) + 32'd1) << r_size) - 32'd1;
  assign w_last  = (r_cnt == r_len);

  always_comb begin
    w_next = w_incr;
    if (r_burst == 2'b00)
      w_next = r_addr;
    else if (w_wrap)
      w_next = (r_addr & ~w_mask) | (w_incr & w_mask);
  end

  always_ff @(posedge aclk or negedge rst_l) begin
    if (!rst_l) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_id    <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_size  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_resp  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (s_arvalid) begin
          r_addr  <= s_araddr;
          r_id    <= s_arid;
          r_len   <= s_arlen;
          r_burst <= s_arburst;
          r_size  <= w_esize;
          r_cnt   <= '0;
          r_state <= S_ADDR;
        end
        S_ADDR: if (m_arready) r_state <= S_DATA;
        S_DATA: if (m_rvalid) begin
          r_data  <= m_rdata;
          r_resp  <= (r_burst == 2'b11) ? 2'b10 : m_rresp;
          r_state <= S_RESP;
        end
        default: if (s_rready) begin
          if (w_last) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt   <= r_cnt + 8'd1;
            r_addr  <= w_next;
            r_state <= S_ADDR;
          end
        end
      endcase
    end
  end

  assign s_arready = (r_state == S_IDLE);
  assign m_arvalid = (r_state == S_ADDR);
  assign m_rready  = (r_state == S_DATA);
  assign s_rvalid  = (r_state == S_RESP);
  assign s_rlast   = s_rvalid && w_last;
  assign s_rdata   = r_data;
  assign s_rresp   = r_resp;
  assign s_rid     = r_id;
  assign m_araddr  = r_addr;
  assign m_arid    = r_id;
  assign m_arlen   = 8'd0;
  assign m_arburst = 2'b01;
  assign m_arsize  = r_size;
endmodule

// File: tb/tb_axi_rd_burst_split.sv
// Directed bench for axi_rd_burst_split with a one-outstanding memory slave whose
// data and response are simple functions of the read address.
module tb_axi_rd_burst_split;
  localparam int TAGW = 4;

  logic            aclk = 1'b0;
  logic            rst_l;
  logic            s_arvalid, s_arready;
  logic [31:0]     s_araddr;
  logic [TAGW-1:0] s_arid;
  logic [7:0]      s_arlen;
  logic [1:0]      s_arburst;
  logic [2:0]      s_arsize;
  logic            s_rvalid, s_rready;
  logic [63:0]     s_rdata;
  logic [1:0]      s_rresp;
  logic [TAGW-1:0] s_rid;
  logic            s_rlast;
  logic            m_arvalid, m_arready;
  logic [31:0]     m_araddr;
  logic [TAGW-1:0] m_arid;
  logic [7:0]      m_arlen;
  logic [1:0]      m_arburst;
  logic [2:0]      m_arsize;
  logic            m_rvalid, m_rready;
  logic [63:0]     m_rdata;
  logic [1:0]      m_rresp;
  logic [TAGW-1:0] m_rid;
  logic            m_rlast;

  axi_rd_burst_split #(.TAGW(TAGW)) dut (
    .aclk(aclk), .rst_l(rst_l),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arburst(s_arburst), .s_arsize(s_arsize),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rid(s_rid), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arburst(m_arburst), .m_arsize(m_arsize),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rid(m_rid), .m_rlast(m_rlast)
  );

  always #5 aclk = ~aclk;

  // Memory slave: always ready for an address, answers one cycle later.
  logic        sl_pend = 1'b0;
  logic [31:0] sl_addr = 32'd0;
  always @(posedge aclk) begin
    if (m_arvalid && m_arready) begin
      sl_pend <= 1'b1;
      sl_addr <= m_araddr;
    end else if (m_rvalid && m_rready) begin
      sl_pend <= 1'b0;
    end
  end
  assign m_arready = 1'b1;
  assign m_rvalid  = sl_pend;
  assign m_rdata   = {sl_addr ^ 32'hDEADBEEF, sl_addr};
  assign m_rresp   = sl_addr[4:3];
  assign m_rid     = '0;
  assign m_rlast   = 1'b1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Observations of the most recent beat
  int          ob_cyc;
  logic        ob_found;
  logic [31:0] ob_addr;
  logic [2:0]  ob_size;
  logic [TAGW-1:0] ob_arid;
  logic [7:0]  ob_len;
  logic [1:0]  ob_burst;

  logic [31:0] exp_a [0:7];

  task automatic get_beat();
    ob_cyc = 0; ob_found = 1'b0;
    ob_addr = 32'h0; ob_size = 3'h7; ob_arid = '1; ob_len = 8'hFF; ob_burst = 2'b11;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      ob_cyc++;
      if (m_arvalid) begin
        ob_addr = m_araddr; ob_size = m_arsize; ob_arid = m_arid;
        ob_len = m_arlen; ob_burst = m_arburst;
      end
      if (s_rvalid) begin
        ob_found = 1'b1;
        break;
      end
    end
  endtask

  task automatic issue(input string nm, input logic [31:0] a, input logic [TAGW-1:0] id,
                       input logic [7:0] len, input logic [1:0] bu, input logic [2:0] sz);
    @(negedge aclk);
    chk({nm, "_arready"}, 64'(s_arready), 64'd1);
    s_araddr = a; s_arid = id; s_arlen = len; s_arburst = bu; s_arsize = sz; s_arvalid = 1'b1;
    @(posedge aclk);
    #1;
    s_arvalid = 1'b0; s_araddr = 32'hBAD0BAD0; s_arid = '0; s_arlen = 8'h55;
    s_arburst = 2'b00; s_arsize = 3'd0;
  endtask

  task automatic chk_beat(input string nm, input logic [31:0] ea, input logic [TAGW-1:0] id,
                          input logic [1:0] bu, input logic [2:0] esz, input logic last);
    chk({nm, "_found"}, 64'(ob_found), 64'd1);
    chk({nm, "_cycles"}, 64'(ob_cyc), 64'd3);
    chk({nm, "_m_araddr"}, 64'(ob_addr), 64'(ea));
    chk({nm, "_m_arsize"}, 64'(ob_size), 64'(esz));
    chk({nm, "_m_arid"}, 64'(ob_arid), 64'(id));
    chk({nm, "_m_arlen"}, 64'(ob_len), 64'd0);
    chk({nm, "_m_arburst"}, 64'(ob_burst), 64'd1);
    chk({nm, "_s_rdata"}, s_rdata, {ea ^ 32'hDEADBEEF, ea});
    chk({nm, "_s_rresp"}, 64'(s_rresp), (bu == 2'b11) ? 64'd2 : 64'(ea[4:3]));
    chk({nm, "_s_rid"}, 64'(s_rid), 64'(id));
    chk({nm, "_s_rlast"}, 64'(s_rlast), 64'(last));
  endtask

  task automatic run_burst(input string nm, input logic [31:0] a, input logic [TAGW-1:0] id,
                           input logic [7:0] len, input logic [1:0] bu, input logic [2:0] sz,
                           input logic [2:0] esz);
    issue(nm, a, id, len, bu, sz);
    for (int b = 0; b <= int'(len); b++) begin
      get_beat();
      chk_beat($sformatf("%s_b%0d", nm, b), exp_a[b], id, bu, esz, b == int'(len));
    end
    @(posedge aclk);
    #1;
    chk({nm, "_idle_after"}, 64'(s_arready), 64'd1);
    chk({nm, "_rvalid_after"}, 64'(s_rvalid), 64'd0);
  endtask

  logic [63:0]     hold_data;
  logic [TAGW-1:0] hold_id;
  logic            hold_last;

  initial begin
    rst_l = 1'b0; s_arvalid = 1'b0; s_araddr = '0; s_arid = '0; s_arlen = '0;
    s_arburst = '0; s_arsize = '0; s_rready = 1'b1;
    #1;
    chk("rst_s_arready", 64'(s_arready), 64'd1);
    chk("rst_s_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_m_rready", 64'(m_rready), 64'd0);
    chk("rst_s_rlast", 64'(s_rlast), 64'd0);
    chk("rst_s_rdata", s_rdata, 64'd0);
    repeat (3) @(negedge aclk);
    rst_l = 1'b1;

    exp_a[0] = 32'h1000; exp_a[1] = 32'h1008; exp_a[2] = 32'h1010; exp_a[3] = 32'h1018;
    run_burst("incr", 32'h1000, 4'h3, 8'd3, 2'b01, 3'd3, 3'd3);

    exp_a[0] = 32'h1018; exp_a[1] = 32'h1000; exp_a[2] = 32'h1008; exp_a[3] = 32'h1010;
    run_burst("wrap", 32'h1018, 4'hA, 8'd3, 2'b10, 3'd3, 3'd3);

    exp_a[0] = 32'h2004; exp_a[1] = 32'h2004; exp_a[2] = 32'h2004;
    run_burst("fixed", 32'h2004, 4'h6, 8'd2, 2'b00, 3'd2, 3'd2);

    exp_a[0] = 32'h1010; exp_a[1] = 32'h1018; exp_a[2] = 32'h1020;
    run_burst("wrap_len2", 32'h1010, 4'h1, 8'd2, 2'b10, 3'd3, 3'd3);

    exp_a[0] = 32'h5000; exp_a[1] = 32'h5008;
    run_burst("resv", 32'h5000, 4'hC, 8'd1, 2'b11, 3'd3, 3'd3);

    // Oversized arsize clamps to 8-byte beats; address rolls over to zero.
    exp_a[0] = 32'hFFFFFFF8; exp_a[1] = 32'h0;
    run_burst("incr_top", 32'hFFFFFFF8, 4'h2, 8'd1, 2'b01, 3'd6, 3'd3);

    // Upstream backpressure on the second beat
    issue("bp", 32'h6000, 4'h5, 8'd1, 2'b01, 3'd3);
    get_beat();
    chk_beat("bp_b0", 32'h6000, 4'h5, 2'b01, 3'd3, 1'b0);
    @(posedge aclk);
    #1 s_rready = 1'b0;
    get_beat();
    chk_beat("bp_b1", 32'h6008, 4'h5, 2'b01, 3'd3, 1'b1);
    hold_data = s_rdata; hold_id = s_rid; hold_last = s_rlast;
    repeat (5) begin
      @(negedge aclk);
      chk("bp_rvalid", 64'(s_rvalid), 64'd1);
      chk("bp_rdata", s_rdata, hold_data);
      chk("bp_rid", 64'(s_rid), 64'(hold_id));
      chk("bp_rlast", 64'(s_rlast), 64'(hold_last));
      chk("bp_arvalid", 64'(m_arvalid), 64'd0);
    end
    s_rready = 1'b1;
    @(posedge aclk);
    #1;
    chk("bp_idle_after", 64'(s_arready), 64'd1);
    chk("bp_rvalid_after", 64'(s_rvalid), 64'd0);

    // Reset while the second beat of an 8-beat burst waits for data
    issue("rstm", 32'h3000, 4'h9, 8'd7, 2'b01, 3'd3);
    get_beat();
    chk_beat("rstm_b0", 32'h3000, 4'h9, 2'b01, 3'd3, 1'b0);
    @(posedge aclk);
    @(posedge aclk);
    #1;
    chk("rstm_in_data", 64'(m_rready), 64'd1);
    rst_l = 1'b0;
    #1;
    chk("rstm_rvalid", 64'(s_rvalid), 64'd0);
    chk("rstm_rready", 64'(m_rready), 64'd0);
    chk("rstm_arvalid", 64'(m_arvalid), 64'd0);
    chk("rstm_arready", 64'(s_arready), 64'd1);
    chk("rstm_rdata_clr", s_rdata, 64'd0);
    repeat (2) @(negedge aclk);
    rst_l = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      chk("rstm_quiet_rvalid", 64'(s_rvalid), 64'd0);
      chk("rstm_quiet_arvalid", 64'(m_arvalid), 64'd0);
      chk("rstm_quiet_arready", 64'(s_arready), 64'd1);
    end
    exp_a[0] = 32'h4000; exp_a[1] = 32'h4008;
    run_burst("post_rst", 32'h4000, 4'h7, 8'd1, 2'b01, 3'd3, 3'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
